// File: rtl/stream_64b_to_32b_pkg.sv
// stream_64b_to_32b_pkg: lane geometry and the state encoding shared by the 64b<->32b packer and serializer
package stream_64b_to_32b_pkg;
  localparam int ACT_DATA_WIDTH = 8;
  localparam int N_DIM_ARRAY = 4;
  localparam int NARROW_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int WIDE_W = 2 * NARROW_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;
endpackage

// File: rtl/stream_64b_to_32b_if.sv
// stream_64b_to_32b_if: wide-in / narrow-out handshake bundle of the serializer
interface stream_64b_to_32b_if;
  import stream_64b_to_32b_pkg::*;
  logic input_en;
  logic input_ready;
  logic signed [WIDE_W-1:0] input_word;
  logic [31:0] input_addr;
  logic input_half_only;
  logic signed [NARROW_W-1:0] output_word;
  logic [31:0] output_addr;
  logic output_en;
  logic output_ready;
  modport master (
    output input_en, input_word, input_addr, input_half_only, output_ready,
    input input_ready, output_word, output_addr, output_en
  );
  modport slave (
    input input_en, input_word, input_addr, input_half_only, output_ready,
    output input_ready, output_word, output_addr, output_en
  );
endinterface

// File: rtl/stream_64b_to_32b.sv
// stream_64b_to_32b: splits each wide word into two narrow beats, low lanes first, with a half-only tail
module stream_64b_to_32b
  import stream_64b_to_32b_pkg::*;
(
  input  logic clk,
  input  logic reset,
  stream_64b_to_32b_if.slave s,
  output logic busy
);
  state_t state;
  logic [WIDE_W-1:0] held_word;
  logic [31:0] held_addr;
  logic held_half;
  logic last;
  logic take;
  // last beat lets the next wide word in on the same edge so streams carry no bubble
  assign last = state == HIGH || (state == LOW && held_half);
  assign s.input_ready = !reset && (state == EMPTY || (last && s.output_ready));
  assign take = s.input_en && s.input_ready;
  assign s.output_en = state == LOW || state == HIGH;
  assign s.output_word = state == HIGH ? held_word[WIDE_W-1:NARROW_W]
                       : state == LOW  ? held_word[NARROW_W-1:0] : '0;
  assign s.output_addr = s.output_en ? {held_addr[30:0], state == HIGH} : '0;
  assign busy = state != EMPTY;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= EMPTY;
      held_word <= '0;
      held_addr <= '0;
      held_half <= 1'b0;
    end else begin
      if (take) begin
        held_word <= s.input_word;
        held_addr <= s.input_addr;
        held_half <= s.input_half_only;
      end
      state <= take ? LOW
             : (state == LOW && !held_half) ? (s.output_ready ? HIGH : LOW)
             : (last && !s.output_ready) ? state : EMPTY;
    end
endmodule

// File: tb/tb_stream_64b_to_32b.sv
// tb_stream_64b_to_32b: scenario tasks plus a scoreboard of expected narrow beats
module tb_stream_64b_to_32b;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  stream_64b_to_32b_if bus();
  stream_64b_to_32b dut (.clk(clk), .reset(reset), .s(bus), .busy(busy));
  always #5 clk = ~clk;

  task automatic monitor();
    logic [63:0] e;
    logic [63:0] w;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (bus.output_en && bus.output_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got %h@%h, none expected", bus.output_word, bus.output_addr);
        end else begin
          e = sb.pop_front();
          if ({bus.output_word, bus.output_addr} !== e) begin
            failures++;
            $display("FAIL beat got %h@%h expected %h@%h", bus.output_word, bus.output_addr, e[63:32], e[31:0]);
          end
        end
      end
      if (bus.input_en && bus.input_ready) begin
        w = bus.input_word;
        a = bus.input_addr << 1;
        sb.push_back({w[31:0], a});
        if (!bus.input_half_only) sb.push_back({w[63:32], a | 32'd1});
      end
    end
  endtask

  task automatic send(input logic [63:0] w, input logic [31:0] a, input logic h);
    int n = 0;
    bus.input_en = 1'b1;
    bus.input_word = w;
    bus.input_addr = a;
    bus.input_half_only = h;
    @(negedge clk);
    while (!bus.input_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout input_ready stuck at %b, required 1", bus.input_ready);
    end
    @(posedge clk);
    #1 bus.input_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain busy=%b pending=%0d, required busy=0 pending=0", name, busy, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.input_en = 1'b0;
    bus.input_word = '0;
    bus.input_addr = '0;
    bus.input_half_only = 1'b0;
    bus.output_ready = 1'b1;
    reset = 1'b1;
    #3;
    checks++;
    if ({bus.input_ready, bus.output_en, busy, bus.output_word, bus.output_addr} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b en=%b busy=%b word=%h addr=%h, required all 0",
               bus.input_ready, bus.output_en, busy, bus.output_word, bus.output_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.input_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release rdy=%b busy=%b, required rdy=1 busy=0", bus.input_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bus.output_ready = 1'b1;
    send(64'h8877665544332211, 32'h10, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.output_en !== 1'b1 || bus.output_word !== 32'h44332211 || bus.output_addr !== 32'h20) begin
      failures++;
      $display("FAIL basic_low got en=%b %h@%h, required 1 44332211@00000020", bus.output_en, bus.output_word, bus.output_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.output_word !== 32'h88776655 || bus.output_addr !== 32'h21 || bus.input_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_high got %h@%h rdy=%b, required 88776655@00000021 rdy=1", bus.output_word, bus.output_addr, bus.input_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.output_en !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle busy=%b en=%b, required 0 0", busy, bus.output_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    logic acc;
    bus.output_ready = 1'b1;
    bus.input_half_only = 1'b0;
    bus.input_en = 1'b1;
    bus.input_word = {$urandom, $urandom};
    bus.input_addr = 32'h100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.output_en !== (c >= 1 && c <= 8)) begin
        failures++;
        $display("FAIL b2b_en cycle %0d got %b required %b", c, bus.output_en, c >= 1 && c <= 8);
      end
      checks++;
      if (bus.input_ready !== (c == 0 || (c >= 2 && c % 2 == 0) || c >= 9)) begin
        failures++;
        $display("FAIL b2b_ready cycle %0d got %b", c, bus.input_ready);
      end
      acc = bus.input_en && bus.input_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 4) begin
          bus.input_word = {$urandom, $urandom};
          bus.input_addr = 32'h100 + k * 3;
        end else bus.input_en = 1'b0;
      end
    end
    wait_idle("b2b");
  endtask

  task automatic test_backpressure();
    logic [63:0] w;
    w = {$urandom, $urandom};
    bus.output_ready = 1'b0;
    send(w, 32'h4000_0123, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.output_en !== 1'b1 || bus.output_word !== w[31:0] || bus.output_addr !== 32'h8000_0246 || bus.input_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_low got en=%b %h@%h rdy=%b, required 1 %h@80000246 rdy=0",
                 bus.output_en, bus.output_word, bus.output_addr, bus.input_ready, w[31:0]);
      end
    end
    @(posedge clk);
    #1 bus.output_ready = 1'b1;
    @(posedge clk);
    #1 bus.output_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.output_en !== 1'b1 || bus.output_word !== w[63:32] || bus.output_addr !== 32'h8000_0247 || bus.input_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_high got en=%b %h@%h rdy=%b, required 1 %h@80000247 rdy=0",
                 bus.output_en, bus.output_word, bus.output_addr, bus.input_ready, w[63:32]);
      end
    end
    @(posedge clk);
    #1 bus.output_ready = 1'b1;
    wait_idle("bp");
  endtask

  task automatic test_half_only();
    bus.output_ready = 1'b1;
    send(64'hDEADBEEF_CAFEF00D, 32'h7, 1'b1);
    bus.input_en = 1'b1;
    bus.input_word = 64'h0123456789ABCDEF;
    bus.input_addr = 32'h30;
    bus.input_half_only = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.output_word !== 32'hCAFEF00D || bus.output_addr !== 32'hE || bus.input_ready !== 1'b1) begin
      failures++;
      $display("FAIL half_beat got %h@%h rdy=%b, required cafef00d@0000000e rdy=1", bus.output_word, bus.output_addr, bus.input_ready);
    end
    @(posedge clk);
    #1 bus.input_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.output_en !== 1'b1 || bus.output_word !== 32'h89ABCDEF || bus.output_addr !== 32'h60) begin
      failures++;
      $display("FAIL half_next got en=%b %h@%h, required 1 89abcdef@00000060", bus.output_en, bus.output_word, bus.output_addr);
    end
    wait_idle("half");
  endtask

  task automatic test_wrap();
    bus.output_ready = 1'b1;
    send({$urandom, $urandom}, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.output_addr !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL wrap_low got %h required fffffffe", bus.output_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.output_addr !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL wrap_high got %h required ffffffff", bus.output_addr);
    end
    wait_idle("wrap");
  endtask

  task automatic test_reset_mid();
    bus.output_ready = 1'b0;
    send({$urandom, $urandom}, 32'h55, 1'b0);
    @(posedge clk);
    #1 bus.output_ready = 1'b1;
    @(posedge clk);
    #1 bus.output_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.output_en !== 1'b1 || bus.output_addr !== 32'hAB) begin
      failures++;
      $display("FAIL rmid_high got en=%b addr=%h, required 1 000000ab", bus.output_en, bus.output_addr);
    end
    #2 reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({bus.input_ready, bus.output_en, busy, bus.output_word, bus.output_addr} !== 67'd0) begin
      failures++;
      $display("FAIL rmid_async rdy=%b en=%b busy=%b word=%h addr=%h, required all 0",
               bus.input_ready, bus.output_en, busy, bus.output_word, bus.output_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.output_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.input_ready !== 1'b1 || bus.output_en !== 1'b0) begin
      failures++;
      $display("FAIL rmid_release rdy=%b en=%b, required 1 0", bus.input_ready, bus.output_en);
    end
    repeat (3) @(negedge clk);
    wait_idle("rmid");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_half_only();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
